// File: rtl/pc_call_sequencer_if.sv
// Return-address-stack link: the sequencer drives push/pop requests and
// consumes the stack's top-of-stack target.
interface pc_call_sequencer_if #(
  parameter int unsigned D = 12
) ();
  logic         call;
  logic         ret;
  logic [D-1:0] addr;
  logic [D-1:0] target_in;
  logic [D-1:0] ras_target;

  modport master (
    output call,
    output ret,
    output addr,
    output target_in,
    input  ras_target
  );

  modport slave (
    input  call,
    input  ret,
    input  addr,
    input  target_in,
    output ras_target
  );
endinterface

// File: rtl/pc_call_sequencer.sv
// Three-cycle fetch/exec/resolve PC sequencer that drives the return-address
// stack and tracks its depth so it never overflows or underflows.
module pc_call_sequencer #(
  parameter int unsigned  D           = 12,
  parameter int unsigned  STACK_DEPTH = 8,
  parameter logic [D-1:0] RESET_PC    = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       is_call,
  input  logic                       is_ret,
  input  logic                       is_branch,
  input  logic                       taken,
  input  logic                       is_halt,
  input  logic [D-1:0]               jump_target,
  output logic [D-1:0]               prog_ctr,
  output logic [1:0]                 stage,
  output logic                       done,
  output logic                       ras_fault,
  pc_call_sequencer_if.master        ras
);

  localparam int unsigned    DW   = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0]  Full = DW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StResolve,
    StHalt,
    StFault
  } state_e;

  state_e        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [D-1:0]  addr_q, addr_d;
  logic [D-1:0]  tin_q, tin_d;
  logic [D-1:0]  jt_q, jt_d;
  logic [1:0]    stage_q, stage_d;
  logic          call_q, call_d;
  logic          ret_q, ret_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          op_ret_q, op_ret_d;
  logic          op_jump_q, op_jump_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      tin_q     <= '0;
      jt_q      <= '0;
      stage_q   <= 2'b11;
      call_q    <= 1'b0;
      ret_q     <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      depth_q   <= '0;
      op_ret_q  <= 1'b0;
      op_jump_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      tin_q     <= tin_d;
      jt_q      <= jt_d;
      stage_q   <= stage_d;
      call_q    <= call_d;
      ret_q     <= ret_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
      depth_q   <= depth_d;
      op_ret_q  <= op_ret_d;
      op_jump_q <= op_jump_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    tin_d     = tin_q;
    jt_d      = jt_q;
    call_d    = 1'b0;
    ret_d     = 1'b0;
    done_d    = done_q;
    fault_d   = fault_q;
    depth_d   = depth_q;
    op_ret_d  = op_ret_q;
    op_jump_d = op_jump_q;

    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        jt_d      = jump_target;
        op_ret_d  = 1'b0;
        op_jump_d = 1'b0;
        // Decode priority: halt > ret > call > branch.
        if (is_halt) begin
          state_d = StHalt;
          done_d  = 1'b1;
        end else if (is_ret) begin
          if (depth_q == '0) begin
            state_d = StFault;
            fault_d = 1'b1;
          end else begin
            state_d  = StExec;
            ret_d    = 1'b1;
            op_ret_d = 1'b1;
          end
        end else if (is_call) begin
          if (depth_q == Full) begin
            state_d = StFault;
            fault_d = 1'b1;
          end else begin
            state_d   = StExec;
            call_d    = 1'b1;
            op_jump_d = 1'b1;
            addr_d    = pc_q;
            tin_d     = jump_target;
          end
        end else begin
          state_d   = StExec;
          op_jump_d = is_branch & taken;
        end
      end
      StExec: begin
        state_d = StResolve;
        if (call_q) begin
          depth_d = depth_q + 1'b1;
        end else if (ret_q) begin
          depth_d = depth_q - 1'b1;
        end
      end
      StResolve: begin
        state_d = StFetch;
        if (op_ret_q) begin
          pc_d = ras.ras_target;
        end else if (op_jump_q) begin
          pc_d = jt_q;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: ; // HALT and FAULT hold until reset
    endcase
  end

  // Stage is registered alongside the state it encodes.
  always_comb begin
    stage_d = 2'b11;
    case (state_d)
      StFetch:   stage_d = 2'b00;
      StExec:    stage_d = 2'b01;
      StResolve: stage_d = 2'b10;
      default:   stage_d = 2'b11;
    endcase
  end

  assign prog_ctr      = pc_q;
  assign stage         = stage_q;
  assign done          = done_q;
  assign ras_fault     = fault_q;
  assign ras.call      = call_q;
  assign ras.ret       = ret_q;
  assign ras.addr      = addr_q;
  assign ras.target_in = tin_q;

endmodule
